decoder: RTL
============

Name: decoder

Overview:
- Control stage directly downstream of the instruction fetcher in the 8-bit vtisa CPU.
- Consumes the latched `instr` and the RAM-fetched word, and decodes the 4-bit opcode / 4-bit operand.
- Owns the CPU state register, `pc`, the accumulator, and the fetch source and RAM address that drive the fetcher.
- Runs a multi-cycle FSM: fetch, decode/execute, optional memory load, write-back.

Parameters:
- BITS, 8: datapath and pc width.
- STATE_BITS, 3: state encoding width.
- RESET_PC, 8'h00: pc value loaded at reset.

Ports:
- clk  input  1  system clock, all flops on rising edge.
- reset  input  1  asynchronous, active-low reset.
- instr  input  BITS  instruction word latched by the fetcher; valid in STATE_DECODE.
- mem_data  input  BITS  RAM word latched by the fetcher (its acc output); valid in STATE_LOAD_WB.
- state  output  STATE_BITS  current CPU state; the fetcher acts only in STATE_FETCH.
- pc  output  BITS  program counter, the ROM address.
- fetch_source  output  1  FETCH_ROM or FETCH_RAM.
- ram_addr  output  BITS  RAM address used when fetch_source==FETCH_RAM.
- acc  output  BITS  architectural accumulator.
- halted  output  1  high while in STATE_HALT.
- illegal  output  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Reset (reset==0, async): state=STATE_RESET, pc=RESET_PC, fetch_source=FETCH_ROM, ram_addr=0, acc=0, halted=0, illegal=0.
- Reset mid-instruction aborts it with no partial update.
- First rising edge after release: RESET->FETCH.
- Encoding: opcode=instr[7:4], imm=instr[3:0], imm zero-extended to BITS.
- FETCH with fetch_source==ROM: the fetcher latches instr this edge; next state DECODE.
- FETCH with fetch_source==RAM (load data phase): next state LOAD_WB.
- DECODE executes:
  - 0x0 NOP: pc+1.
  - 0x1 LDI: acc<=imm; pc+1.
  - 0x2 LD: ram_addr<=imm; fetch_source<=RAM; pc unchanged; next FETCH.
  - 0x3 ADDI: acc<=acc+imm mod 2^BITS, carry discarded (0xFF+1=0x00); pc+1.
  - 0x4 JMP: pc<=imm.
  - 0x5 JZ: pc<=imm if acc==0, else pc+1.
  - 0xF HLT: next HALT; pc unchanged.
  - Any other opcode: treated as NOP; illegal=1 for exactly the following cycle.
  - All opcodes except LD and HLT: next FETCH with fetch_source=ROM.
- LOAD_WB: acc<=mem_data; pc+1; fetch_source<=ROM; next FETCH.
- HALT: absorbing; no register changes; halted=1 combinationally from state. Only reset exits.
- pc arithmetic is mod 2^BITS: pc 0xFF + 1 wraps to 0x00.
- Instruction latency from the first FETCH cycle:
  - Non-load instructions: 2 cycles.
  - LD: 4 cycles (FETCH, DECODE, FETCH-RAM, LOAD_WB).
- ram_addr holds its last value outside loads.
- Unused state encodings go to STATE_FETCH with fetch_source=ROM.
- The fetcher's next_state output is ignored; this block is the single owner of state.

Decomposition:
- Shared package `cpu_pkg` holds:
  - BITS_IDX, STATE_BITS_IDX.
  - STATE_RESET=0, STATE_FETCH=1, STATE_DECODE=2, STATE_LOAD_WB=3, STATE_HALT=4.
  - FETCH_ROM=0, FETCH_RAM=1.
  - Opcode constants OP_NOP, OP_LDI, OP_LD, OP_ADDI, OP_JMP, OP_JZ, OP_HLT.
- The same package is used by the fetcher.
- One natural sub-module, `alu`: combinational; inputs opcode, acc, imm; outputs next acc and a zero flag.
- The FSM, pc and address logic stay in decoder.

Test Plan:
- Reset and program run: hold reset low for 3 cycles, release; state goes RESET->FETCH->DECODE; all outputs match reset values before the first edge.
- ROM {0x17, 0x35, 0xF0}: acc=0x07, then 0x0C; then halted=1, pc=0x02 and stays for 10 cycles.
- LD: ROM {0x25}, RAM[5]=0xA3. Required sequence:
  - DECODE cycle drives ram_addr=0x05 and fetch_source=RAM.
  - LOAD_WB yields acc=0xA3, pc=0x01, fetch_source=ROM.
  - Total 4 cycles.
- Branch: ROM {0x10, 0x59} -> pc=0x09 after JZ. ROM {0x11, 0x59} -> pc=0x02.
- Wrap and illegal:
  - acc=0xFF then ADDI 1 -> acc=0x00.
  - pc=0xFF executing NOP -> pc=0x00.
  - Opcode 0x8 -> illegal pulses exactly 1 cycle, pc+1.
- Async reset asserted mid-LD, in the FETCH-RAM cycle, between clock edges: outputs reset immediately; acc stays 0; execution restarts at pc=0x00.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared vtisa definitions: CPU state encoding, fetch source select and opcodes.
// Used by both the fetcher and the decoder.
package cpu_pkg;

    localparam int BITS_IDX       = 7;
    localparam int STATE_BITS_IDX = 2;

    typedef enum logic [STATE_BITS_IDX:0] {
        STATE_RESET   = 3'd0,
        STATE_FETCH   = 3'd1,
        STATE_DECODE  = 3'd2,
        STATE_LOAD_WB = 3'd3,
        STATE_HALT    = 3'd4
    } state_e;

    localparam logic FETCH_ROM = 1'b0;
    localparam logic FETCH_RAM = 1'b1;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ADDI = 4'h3;
    localparam logic [3:0] OP_JMP  = 4'h4;
    localparam logic [3:0] OP_JZ   = 4'h5;
    localparam logic [3:0] OP_HLT  = 4'hF;

endpackage

// File: rtl/decoder_alu.sv
// Combinational accumulator update for the immediate-form instructions,
// plus the zero flag of the current accumulator used by JZ.
module alu
    import cpu_pkg::*;
#(
    parameter int BITS = BITS_IDX + 1
) (
    input  logic [3:0]      opcode_i,
    input  logic [BITS-1:0] acc_i,
    input  logic [BITS-1:0] imm_i,
    output logic [BITS-1:0] acc_o,
    output logic            zero_o
);

    always_comb begin
        acc_o = acc_i;
        case (opcode_i)
            OP_LDI:  acc_o = imm_i;
            // Carry out of the top bit is dropped: 0xFF + 1 gives 0x00.
            OP_ADDI: acc_o = acc_i + imm_i;
            default: acc_o = acc_i;
        endcase
    end

    assign zero_o = (acc_i == '0);

endmodule

// File: rtl/decoder.sv
// vtisa control stage: owns CPU state, pc, accumulator and the fetch source /
// RAM address that steer the fetcher. One instruction per FETCH..DECODE pass.
module decoder
    import cpu_pkg::*;
#(
    parameter int              BITS       = BITS_IDX + 1,
    parameter int              STATE_BITS = STATE_BITS_IDX + 1,
    parameter logic [BITS-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BITS-1:0]       instr,
    input  logic [BITS-1:0]       mem_data,
    output logic [STATE_BITS-1:0] state,
    output logic [BITS-1:0]       pc,
    output logic                  fetch_source,
    output logic [BITS-1:0]       ram_addr,
    output logic [BITS-1:0]       acc,
    output logic                  halted,
    output logic                  illegal
);

    // Fetcher contract: the fetcher acts only while state==STATE_FETCH. With
    // fetch_source==FETCH_ROM it latches rom[pc] into instr (valid in DECODE);
    // with FETCH_RAM it latches ram[ram_addr] into mem_data (valid in LOAD_WB).
    state_e          state_q;
    logic [BITS-1:0] pc_q;
    logic            fetch_source_q;
    logic [BITS-1:0] ram_addr_q;
    logic [BITS-1:0] acc_q;
    logic            illegal_q;

    logic [3:0]      opcode;
    logic [BITS-1:0] imm;
    logic [BITS-1:0] pc_inc;
    logic [BITS-1:0] alu_acc;
    logic            acc_zero;

    assign opcode = instr[7:4];
    assign imm    = {{(BITS-4){1'b0}}, instr[3:0]};
    assign pc_inc = pc_q + BITS'(1);

    alu #(
        .BITS (BITS)
    ) u_alu (
        .opcode_i (opcode),
        .acc_i    (acc_q),
        .imm_i    (imm),
        .acc_o    (alu_acc),
        .zero_o   (acc_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= STATE_RESET;
            pc_q           <= RESET_PC;
            fetch_source_q <= FETCH_ROM;
            ram_addr_q     <= '0;
            acc_q          <= '0;
            illegal_q      <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            case (state_q)
                STATE_RESET: begin
                    state_q <= STATE_FETCH;
                end
                STATE_FETCH: begin
                    state_q <= (fetch_source_q == FETCH_RAM) ? STATE_LOAD_WB : STATE_DECODE;
                end
                STATE_DECODE: begin
                    state_q        <= STATE_FETCH;
                    fetch_source_q <= FETCH_ROM;
                    case (opcode)
                        OP_NOP: pc_q <= pc_inc;
                        OP_LDI, OP_ADDI: begin
                            acc_q <= alu_acc;
                            pc_q  <= pc_inc;
                        end
                        // pc stays put until the data word is written back.
                        OP_LD: begin
                            ram_addr_q     <= imm;
                            fetch_source_q <= FETCH_RAM;
                        end
                        OP_JMP: pc_q <= imm;
                        OP_JZ:  pc_q <= acc_zero ? imm : pc_inc;
                        OP_HLT: state_q <= STATE_HALT;
                        default: begin
                            pc_q      <= pc_inc;
                            illegal_q <= 1'b1;
                        end
                    endcase
                end
                STATE_LOAD_WB: begin
                    acc_q          <= mem_data;
                    pc_q           <= pc_inc;
                    fetch_source_q <= FETCH_ROM;
                    state_q        <= STATE_FETCH;
                end
                STATE_HALT: begin
                    state_q <= STATE_HALT;
                end
                default: begin
                    state_q        <= STATE_FETCH;
                    fetch_source_q <= FETCH_ROM;
                end
            endcase
        end
    end

    assign state        = state_q;
    assign pc           = pc_q;
    assign fetch_source = fetch_source_q;
    assign ram_addr     = ram_addr_q;
    assign acc          = acc_q;
    assign halted       = (state_q == STATE_HALT);
    assign illegal      = illegal_q;

endmodule
